instruction_fetch_unit: RTL and testbench

- Front-end stage directly upstream of the instruction decoder.
- Holds the fetch PC and issues word reads to instruction memory over a request/acknowledge handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to decode with a valid/accept handshake.
- Accepts redirects from branch/jump resolution. A redirect flushes the FIFO, squashes any in-flight read and restarts fetch at the new target.

---
 rtl/core_constants_pkg.sv | 32 +++
 rtl/fetch_buffer.sv | 61 ++++++
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_constants_pkg.sv
// ============================================================================
// Module  : core_constants_pkg
// Brief   : Shared core constants, fetch state encoding and fetch entry type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package core_constants_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

   localparam int          INSTRUCTION_WIDTH = 32;
   localparam logic [31:0] PC_INCREMENT      = 32'd4;
   localparam logic [31:0] NOP_INSTRUCTION   = 32'h0000_0013;

   typedef struct packed {
      logic [INSTRUCTION_WIDTH-1:0] word;
      logic [31:0]                  pc;
   } fetch_entry_t;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module  : fetch_buffer
// Brief   : Synchronous FIFO with push, pop, flush; reads zero when empty.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign w_do_pop  = i_pop && !o_empty;
   // A full buffer still accepts a push when the head leaves in the same cycle
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module  : instruction_fetch_unit
// Brief   : Fetch PC, instruction memory handshake, fetch FIFO and redirects.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit
   import core_constants_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          BUFFER_DEPTH = 2
) (
   input  logic                         Clock,
   input  logic                         Reset,
   output logic                         ReadRequest,
   output logic [31:0]                  ReadAddress,
   input  logic                         ReadAck,
   input  logic [INSTRUCTION_WIDTH-1:0] ReadData,
   input  logic                         RedirectValid,
   input  logic [31:0]                  RedirectTarget,
   output logic [INSTRUCTION_WIDTH-1:0] Instruction,
   output logic [31:0]                  InstructionPC,
   output logic                         InstructionValid,
   input  logic                         InstructionAccept,
   output logic                         FetchFault,
   output logic [31:0]                  FaultAddress
);

   localparam int CW = $clog2(BUFFER_DEPTH) + 1;

   fetch_state_t  r_state;
   fetch_state_t  w_next_state;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_drain_addr;
   logic [31:0]   r_fault_addr;
   logic          r_fault_pending;

   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic          w_last_slot;
   logic          w_redirect_bad;
   fetch_entry_t  w_push_entry;
   fetch_entry_t  w_head;

   assign w_redirect_bad = is_misaligned(RedirectTarget);
   assign w_pop          = InstructionValid && InstructionAccept && !RedirectValid;
   assign w_last_slot    = (w_count == CW'(BUFFER_DEPTH - 1)) && !w_pop;
   assign w_push_entry   = {ReadData, r_fetch_pc};

   fetch_buffer #(
      .DEPTH (BUFFER_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fetch_buffer (
      .clk     (Clock),
      .rst     (Reset),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .i_flush (RedirectValid),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_comb begin
      w_next_state = r_state;
      w_push       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (RedirectValid) begin
               w_next_state = w_redirect_bad ? ST_FAULT : ST_REQ;
            end else if (!w_full) begin
               w_next_state = ST_REQ;
            end
         end
         ST_REQ: begin
            if (RedirectValid) begin
               if (ReadAck) begin
                  w_next_state = w_redirect_bad ? ST_FAULT : ST_REQ;
               end else begin
                  w_next_state = ST_DRAIN;
               end
            end else if (ReadAck) begin
               w_push = 1'b1;
               if (w_last_slot) begin
                  w_next_state = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            // The squashed read completes here; its data is never buffered
            if (ReadAck) begin
               if (RedirectValid) begin
                  w_next_state = w_redirect_bad ? ST_FAULT : ST_REQ;
               end else begin
                  w_next_state = r_fault_pending ? ST_FAULT : ST_REQ;
               end
            end
         end
         ST_FAULT: begin
            if (RedirectValid && !w_redirect_bad) begin
               w_next_state = ST_REQ;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state         <= ST_IDLE;
         r_fetch_pc      <= RESET_VECTOR;
         r_drain_addr    <= '0;
         r_fault_addr    <= '0;
         r_fault_pending <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (RedirectValid) begin
            r_fetch_pc      <= RedirectTarget;
            r_fault_pending <= w_redirect_bad;
            if (w_redirect_bad) begin
               r_fault_addr <= RedirectTarget;
            end
            // Remember the address already on the bus so it stays stable until acked
            if (r_state == ST_REQ && !ReadAck) begin
               r_drain_addr <= r_fetch_pc;
            end
         end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + PC_INCREMENT;
         end
      end
   end

   assign ReadRequest      = (r_state == ST_REQ) || (r_state == ST_DRAIN);
   assign ReadAddress      = (r_state == ST_DRAIN) ? r_drain_addr : r_fetch_pc;
   assign InstructionValid = !w_empty && (r_state != ST_FAULT);
   assign Instruction      = w_head.word;
   assign InstructionPC    = w_head.pc;
   assign FetchFault       = (r_state == ST_FAULT);
   assign FaultAddress     = r_fault_addr;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module  : tb_instruction_fetch_unit
// Brief   : Directed scoreboard bench for instruction_fetch_unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        ReadRequest;
   logic [31:0] ReadAddress;
   logic        ReadAck = 1'b0;
   logic [31:0] ReadData = '0;
   logic        RedirectValid = 1'b0;
   logic [31:0] RedirectTarget = '0;
   logic [31:0] Instruction;
   logic [31:0] InstructionPC;
   logic        InstructionValid;
   logic        InstructionAccept = 1'b0;
   logic        FetchFault;
   logic [31:0] FaultAddress;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_q[$];
   logic [63:0] popped[$];
   logic [31:0] acked[$];
   bit          squash       = 1'b0;
   bit          prev_pending = 1'b0;
   logic [31:0] prev_addr    = '0;

   instruction_fetch_unit #(
      .RESET_VECTOR (32'h0000_0000),
      .BUFFER_DEPTH (2)
   ) dut (
      .Clock             (Clock),
      .Reset             (Reset),
      .ReadRequest       (ReadRequest),
      .ReadAddress       (ReadAddress),
      .ReadAck           (ReadAck),
      .ReadData          (ReadData),
      .RedirectValid     (RedirectValid),
      .RedirectTarget    (RedirectTarget),
      .Instruction       (Instruction),
      .InstructionPC     (InstructionPC),
      .InstructionValid  (InstructionValid),
      .InstructionAccept (InstructionAccept),
      .FetchFault        (FetchFault),
      .FaultAddress      (FaultAddress)
   );

   always #5 Clock = ~Clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h00A0_0113;
         default:       return a ^ 32'h1357_9BDF;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle: sample/compare at the falling edge, then drive the next inputs
   task automatic step(input bit acc, input bit ack, input bit rv,
                       input logic [31:0] rt, input bit rst);
      if (prev_pending) begin
         check("req_held", 64'(ReadRequest), 64'd1);
         check("addr_held", 64'(ReadAddress), 64'(prev_addr));
      end
      check("valid_vs_model", 64'(InstructionValid), 64'(exp_q.size() != 0));
      if (InstructionValid && acc && exp_q.size() != 0) begin
         check("decode_entry", {InstructionPC, Instruction}, exp_q.pop_front());
         popped.push_back({InstructionPC, Instruction});
      end
      Reset             = rst;
      InstructionAccept = acc;
      RedirectValid     = rv;
      RedirectTarget    = rt;
      ReadAck           = ack && ReadRequest;
      ReadData          = mem_word(ReadAddress);
      if (ReadAck) acked.push_back(ReadAddress);
      if (rst) begin
         exp_q.delete();
         squash       = 1'b0;
         prev_pending = 1'b0;
      end else begin
         if (rv) begin
            exp_q.delete();
            squash = ReadRequest && !ReadAck;
         end else if (ReadAck) begin
            if (squash) squash = 1'b0;
            else        exp_q.push_back({ReadAddress, ReadData});
         end
         prev_pending = ReadRequest && !ReadAck;
         prev_addr    = ReadAddress;
      end
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic do_reset();
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic wait_req(input logic [31:0] addr, input bit acc, input string tag);
      int n = 0;
      while (!(ReadRequest && ReadAddress == addr) && n < 20) begin
         step(acc, 1'b1, 1'b0, 32'h0, 1'b0);
         n++;
      end
      check(tag, 64'(ReadRequest && ReadAddress == addr), 64'd1);
   endtask

   initial begin
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      do_reset();
      check("rst_req",    64'(ReadRequest), 64'd0);
      check("rst_valid",  64'(InstructionValid), 64'd0);
      check("rst_fault",  64'(FetchFault), 64'd0);
      check("rst_faddr",  64'(FaultAddress), 64'd0);
      check("rst_head",   {InstructionPC, Instruction}, 64'd0);

      // Streaming fetch with ack and accept tied high
      acked.delete(); popped.delete();
      repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      check("seq_addr0", 64'(acked[0]), 64'h0);
      check("seq_addr1", 64'(acked[1]), 64'h4);
      check("seq_addr2", 64'(acked[2]), 64'h8);
      check("seq_pop0",  popped[0], {32'h0, 32'h0050_0093});
      check("seq_pop1",  popped[1], {32'h4, 32'h00A0_0113});
      check("seq_rate",  64'(popped.size()), 64'd3);

      // Decoder stalled: buffer fills then fetch idles
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      acked.delete(); popped.delete();
      repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check("stall_pushes", 64'(acked.size()), 64'd2);
      check("stall_idle",   64'(ReadRequest), 64'd0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("stall_onepop", 64'(popped.size()), 64'd1);
      begin
         int n = 0;
         while (!ReadRequest && n < 3) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            n++;
         end
      end
      check("stall_rereq", 64'(ReadRequest), 64'd1);

      // Redirect while a read is outstanding and the ack is late
      do_reset();
      popped.delete();
      wait_req(32'h8, 1'b1, "reach_8");
      step(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
      repeat (3) begin
         check("drain_addr", 64'(ReadAddress), 64'h8);
         step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      end
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      check("drain_acked", 64'(acked[acked.size()-1]), 64'h8);
      check("drain_next", {31'b0, ReadRequest, ReadAddress}, {32'h1, 32'h100});
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("drain_first_pc", 64'(popped[popped.size()-1][63:32]), 64'h100);

      // Redirect coinciding with ack and pop
      do_reset();
      wait_req(32'h8, 1'b1, "reach_8b");
      check("pre_flush_valid", 64'(InstructionValid), 64'd1);
      step(1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
      check("flush_empty", 64'(InstructionValid), 64'd0);
      check("flush_next", {31'b0, ReadRequest, ReadAddress}, {32'h1, 32'h200});
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("flush_pop", popped[popped.size()-1], {32'h200, mem_word(32'h200)});

      // Misaligned redirect with a read outstanding, then recovery
      check("pre_fault_req", {31'b0, ReadRequest, ReadAddress}, {32'h1, 32'h204});
      step(1'b1, 1'b0, 1'b1, 32'h202, 1'b0);
      check("fdrain_flag", 64'(FetchFault), 64'd0);
      check("fdrain_req", {31'b0, ReadRequest, ReadAddress}, {32'h1, 32'h204});
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      repeat (3) begin
         check("fault_flag",  64'(FetchFault), 64'd1);
         check("fault_addr",  64'(FaultAddress), 64'h202);
         check("fault_valid", 64'(InstructionValid), 64'd0);
         check("fault_req",   64'(ReadRequest), 64'd0);
         step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      end
      step(1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
      check("recover_flag", 64'(FetchFault), 64'd0);
      check("recover_req", {31'b0, ReadRequest, ReadAddress}, {32'h1, 32'h300});
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("recover_pop_pc", 64'(popped[popped.size()-1][63:32]), 64'h300);

      // PC wrap at the top of the address space
      step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
      check("wrap_start", 64'(ReadAddress), 64'hFFFF_FFFC);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      check("wrap_next", {31'b0, ReadRequest, ReadAddress}, {32'h1, 32'h0});
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("wrap_pop_hi", 64'(popped[popped.size()-2][63:32]), 64'hFFFF_FFFC);
      check("wrap_pop_lo", popped[popped.size()-1], {32'h0, 32'h0050_0093});

      // Reset in the middle of a drain with a fault pending
      check("pre_drain_req", 64'(ReadRequest), 64'd1);
      step(1'b1, 1'b0, 1'b1, 32'h402, 1'b0);
      check("mid_drain_req", 64'(ReadRequest), 64'd1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check("rst_drain_req",   64'(ReadRequest), 64'd0);
      check("rst_drain_fault", 64'(FetchFault), 64'd0);
      check("rst_drain_faddr", 64'(FaultAddress), 64'd0);
      check("rst_drain_valid", 64'(InstructionValid), 64'd0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("rst_drain_vec", {31'b0, ReadRequest, ReadAddress}, {32'h1, 32'h0});
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("rst_drain_nofault", 64'(FetchFault), 64'd0);
      check("rst_drain_pop", popped[popped.size()-1], {32'h0, 32'h0050_0093});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
